// File: rtl/dsp_pipe_ctrl.sv
// CE / sync-reset controller for the DSP48A1 pipeline stage registers.
// Tracks per-stage valid bits with a valid/ready handshake, flush and drain.
module dsp_pipe_ctrl #(
    parameter int                    NUM_STAGES   = 4,
    parameter logic [NUM_STAGES-1:0] STAGE_EN     = '1,
    parameter int                    FLUSH_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic                              flush,
    input  logic                              drain,
    output logic                              drain_done,
    output logic [NUM_STAGES-1:0]             stage_ce,
    output logic [NUM_STAGES-1:0]             stage_rst,
    output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy,
    output logic                              busy
);

    function automatic int en_below(input int unsigned upto);
        int n;
        n = 0;
        for (int unsigned i = 0; i < upto; i++) begin
            if (STAGE_EN[i]) n++;
        end
        return n;
    endfunction

    localparam int L  = en_below(NUM_STAGES);
    localparam int VW = (L > 0) ? L : 1;
    localparam int OW = $clog2(NUM_STAGES + 1);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [VW-1:0]   v, v_nx, adv;
    logic [OW-1:0]   occ_nx;
    logic            armed;
    logic            idle_or_run, drain_go, accept_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FLUSH;
            cnt       <= CNT_LOAD;
            v         <= '0;
            occupancy <= '0;
            armed     <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            v         <= v_nx;
            occupancy <= occ_nx;
            if (drain_go)
                armed <= 1'b0;
            else if (!drain)
                armed <= 1'b1;
        end
    end

    always_comb begin
        logic nxt;
        logic carry;
        adv      = '0;
        v_nx     = '0;
        occ_nx   = '0;
        state_nx = state;
        cnt_nx   = cnt;

        idle_or_run = (state == S_IDLE) || (state == S_RUN);
        drain_go    = idle_or_run && drain && armed && !flush;
        accept_ok   = idle_or_run && !flush && !(drain && armed);

        // Advance chain walks from the output back towards the input.
        nxt = out_ready;
        for (int unsigned j = 0; j < L; j++) begin
            adv[L-1-j] = ~v[L-1-j] | nxt;
            nxt        = adv[L-1-j];
        end

        if (L == 0) begin
            in_ready  = accept_ok & out_ready;
            out_valid = accept_ok & in_valid;
        end else begin
            in_ready  = accept_ok & adv[0];
            out_valid = v[VW-1];
        end

        carry = in_valid & in_ready;
        for (int unsigned k = 0; k < L; k++) begin
            v_nx[k] = adv[k] ? carry : v[k];
            carry   = v[k];
        end
        if (flush || state == S_FLUSH)
            v_nx = '0;

        for (int unsigned k = 0; k < L; k++)
            occ_nx = occ_nx + OW'(v_nx[k]);

        unique case (state)
            S_FLUSH: begin
                if (cnt == '0)
                    state_nx = S_IDLE;
                else
                    cnt_nx = cnt - CW'(1);
            end
            S_IDLE, S_RUN: begin
                if (drain_go)
                    state_nx = S_DRAIN;
                else
                    state_nx = (v_nx != '0) ? S_RUN : S_IDLE;
            end
            S_DRAIN: begin
                if (v == '0)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_FLUSH;
        endcase

        if (flush) begin
            state_nx = S_FLUSH;
            cnt_nx   = CNT_LOAD;
        end

        drain_done = (state == S_DRAIN) && !flush && (v == '0);
        busy       = (state != S_IDLE);
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
        if (STAGE_EN[i]) begin : g_reg
            localparam int R = en_below(i);
            assign stage_ce[i]  = (state != S_FLUSH) & adv[R];
            assign stage_rst[i] = (state == S_FLUSH);
        end else begin : g_byp
            assign stage_ce[i]  = 1'b1;
            assign stage_rst[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Bench for dsp_pipe_ctrl: a 4-deep and a 2-of-4 (0101) instance against an
// occupancy-slot reference model, directed scenarios followed by random traffic.
module tb_dsp_pipe_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic iv [2];
    logic ordy [2];
    logic fl [2];
    logic dr [2];
    logic o_ir [2];
    logic o_ov [2];
    logic o_dd [2];
    logic o_busy [2];
    logic [3:0] o_ce [2];
    logic [3:0] o_rst [2];
    logic [2:0] o_occ [2];

    always #5 clk = ~clk;

    dsp_pipe_ctrl #(.NUM_STAGES(4), .STAGE_EN(4'b1111), .FLUSH_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(o_ir[0]),
        .out_valid(o_ov[0]), .out_ready(ordy[0]), .flush(fl[0]), .drain(dr[0]),
        .drain_done(o_dd[0]), .stage_ce(o_ce[0]), .stage_rst(o_rst[0]),
        .occupancy(o_occ[0]), .busy(o_busy[0])
    );

    dsp_pipe_ctrl #(.NUM_STAGES(4), .STAGE_EN(4'b0101), .FLUSH_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(o_ir[1]),
        .out_valid(o_ov[1]), .out_ready(ordy[1]), .flush(fl[1]), .drain(dr[1]),
        .drain_done(o_dd[1]), .stage_ce(o_ce[1]), .stage_rst(o_rst[1]),
        .occupancy(o_occ[1]), .busy(o_busy[1])
    );

    // Reference model: which registered slots hold an item, plus flush/drain bookkeeping.
    bit slot [2][4];
    int flush_left [2];
    bit draining [2];
    bit armed [2];
    bit e_adv [2][4];
    bit e_rdy [2];
    bit e_trig [2];
    int out_obs [2];
    int out_exp [2];
    int n_assert = 0;
    int n_fail   = 0;

    function automatic int len_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic logic [3:0] en_of(input int d);
        return (d == 0) ? 4'b1111 : 4'b0101;
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h at %0t", tag, d, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) slot[d][k] = 1'b0;
            flush_left[d] = 2;
            draining[d]   = 1'b0;
            armed[d]      = 1'b1;
        end
    endtask

    task automatic eval(input int d);
        int L;
        int c;
        int r;
        bit in_fl;
        logic [3:0] en;
        logic [3:0] ce;
        logic [3:0] rs;
        L     = len_of(d);
        en    = en_of(d);
        in_fl = !rst_n || (flush_left[d] > 0);
        c = 0;
        for (int k = 0; k < L; k++) c += int'(slot[d][k]);
        // A stage moves when downstream there is a hole or the output is taken.
        for (int k = 0; k < L; k++) begin
            e_adv[d][k] = ordy[d];
            for (int j = k; j < L; j++)
                if (!slot[d][j]) e_adv[d][k] = 1'b1;
        end
        e_trig[d] = !in_fl && !draining[d] && dr[d] && armed[d] && !fl[d];
        e_rdy[d]  = !in_fl && !draining[d] && !fl[d] && !(dr[d] && armed[d]) && e_adv[d][0];
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                ce[i] = !in_fl && e_adv[d][r];
                rs[i] = in_fl;
                r++;
            end else begin
                ce[i] = 1'b1;
                rs[i] = 1'b0;
            end
        end
        chk("in_ready",   d, 32'(o_ir[d]),   32'(e_rdy[d]));
        chk("out_valid",  d, 32'(o_ov[d]),   32'(!in_fl && slot[d][L-1]));
        chk("drain_done", d, 32'(o_dd[d]),   32'(!in_fl && draining[d] && !fl[d] && c == 0));
        chk("occupancy",  d, 32'(o_occ[d]),  32'(c));
        chk("busy",       d, 32'(o_busy[d]), 32'(in_fl || draining[d] || c > 0));
        chk("stage_ce",   d, 32'(o_ce[d]),   32'(ce));
        chk("stage_rst",  d, 32'(o_rst[d]),  32'(rs));
        if (o_ov[d] && ordy[d]) out_obs[d]++;
        if (!in_fl && slot[d][L-1] && ordy[d]) out_exp[d]++;
    endtask

    task automatic upd(input int d);
        int L;
        int c;
        int k;
        bit acc;
        if (!rst_n) return;
        L   = len_of(d);
        acc = iv[d] && e_rdy[d];
        c = 0;
        for (int i = 0; i < L; i++) c += int'(slot[d][i]);
        if (fl[d]) begin
            for (int i = 0; i < 4; i++) slot[d][i] = 1'b0;
            flush_left[d] = 2;
            draining[d]   = 1'b0;
        end else if (flush_left[d] > 0) begin
            flush_left[d]--;
        end else begin
            for (int j = 0; j < L; j++) begin
                k = L - 1 - j;
                if (e_adv[d][k]) begin
                    if (k == 0) slot[d][k] = acc;
                    else        slot[d][k] = slot[d][k-1];
                end
            end
            if (draining[d] && c == 0) draining[d] = 1'b0;
            else if (e_trig[d])        draining[d] = 1'b1;
        end
        if (e_trig[d])   armed[d] = 1'b0;
        else if (!dr[d]) armed[d] = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        eval(0);
        eval(1);
        @(posedge clk);
        upd(0);
        upd(1);
        #1;
    endtask

    task automatic drive(input int d, input bit v, input bit r, input bit f, input bit dn);
        iv[d]   = v;
        ordy[d] = r;
        fl[d]   = f;
        dr[d]   = dn;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            drive(d, 0, 1, 0, 0);
            out_obs[d] = 0;
            out_exp[d] = 0;
        end
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // Streaming on the 4-deep pipe; alternating bubbles on the 2-stage one
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 0, 0);
            drive(1, (i % 2) == 0, 1, 0, 0);
            cycle();
        end
        for (int d = 0; d < 2; d++) drive(d, 0, 1, 0, 0);
        repeat (6) cycle();

        // Backpressure: fill and hold, then release
        for (int d = 0; d < 2; d++) drive(d, 1, 0, 0, 0);
        repeat (8) cycle();
        for (int d = 0; d < 2; d++) drive(d, 0, 1, 0, 0);
        repeat (8) cycle();

        // Flush while draining with a partly full pipe
        for (int d = 0; d < 2; d++) drive(d, 1, 0, 0, 0);
        repeat (3) cycle();
        for (int d = 0; d < 2; d++) drive(d, 0, 0, 0, 1);
        cycle();
        for (int d = 0; d < 2; d++) drive(d, 0, 0, 1, 1);
        cycle();
        for (int d = 0; d < 2; d++) drive(d, 0, 0, 0, 0);
        repeat (4) cycle();

        // Drain with two items, drain held high afterwards must not retrigger
        for (int d = 0; d < 2; d++) drive(d, 1, 0, 0, 0);
        repeat (2) cycle();
        for (int d = 0; d < 2; d++) drive(d, 1, 1, 0, 1);
        repeat (8) cycle();
        for (int d = 0; d < 2; d++) drive(d, 0, 1, 0, 0);
        repeat (2) cycle();
        for (int d = 0; d < 2; d++) drive(d, 0, 1, 0, 1);
        repeat (3) cycle();

        // Random traffic with an asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst_n = 1'b0;
                model_reset();
                repeat (2) cycle();
                rst_n = 1'b1;
            end
            for (int d = 0; d < 2; d++)
                drive(d, ($urandom % 4) != 0, ($urandom % 4) != 0,
                      ($urandom % 40) == 0, ($urandom % 10) == 0);
            cycle();
        end

        for (int d = 0; d < 2; d++) drive(d, 0, 1, 0, 0);
        repeat (10) cycle();
        for (int d = 0; d < 2; d++) chk("out_count", d, 32'(out_obs[d]), 32'(out_exp[d]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
